// File: rtl/mips_cpu_pkg.sv
// Shared MIPS datapath types used by the writeback block and its tag FIFO.
package mips_cpu_pkg;

    typedef logic [4:0]  reg_idx_t;
    typedef logic [31:0] word_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // One candidate register-file write: destination index plus data.
    typedef struct packed {
        reg_idx_t dest;
        word_t    data;
    } wb_req_t;

endpackage

// File: rtl/mips_cpu_writeback_if.sv
// Bus between execute/memory stages, issue logic and the writeback block.
// With MIPS_WB_BYPASS_EN defined the bus also carries the forwarding outputs.
interface mips_cpu_writeback_if #(
    parameter int LOAD_DEPTH = 2
);
    import mips_cpu_pkg::*;

    logic     alu_valid;
    logic     alu_ready;
    reg_idx_t alu_reg;
    word_t    alu_data;

    logic     load_issue;
    logic     load_issue_ready;
    reg_idx_t load_issue_reg;
    logic     load_resp_valid;
    word_t    load_resp_data;

    reg_idx_t query_reg_1;
    reg_idx_t query_reg_2;
    logic     stall_1;
    logic     stall_2;

    logic     write_enable;
    reg_idx_t write_reg;
    word_t    write_data;

    logic [$clog2(LOAD_DEPTH):0] loads_pending;

`ifdef MIPS_WB_BYPASS_EN
    logic     bypass_hit_1;
    logic     bypass_hit_2;
    word_t    bypass_data_1;
    word_t    bypass_data_2;
`endif

    // The writeback block's own view.
    modport master (
`ifdef MIPS_WB_BYPASS_EN
        output bypass_hit_1, bypass_hit_2, bypass_data_1, bypass_data_2,
`endif
        input  alu_valid, alu_reg, alu_data,
        input  load_issue, load_issue_reg, load_resp_valid, load_resp_data,
        input  query_reg_1, query_reg_2,
        output alu_ready, load_issue_ready, stall_1, stall_2,
        output write_enable, write_reg, write_data, loads_pending
    );

    // The surrounding pipeline's view.
    modport slave (
`ifdef MIPS_WB_BYPASS_EN
        input  bypass_hit_1, bypass_hit_2, bypass_data_1, bypass_data_2,
`endif
        output alu_valid, alu_reg, alu_data,
        output load_issue, load_issue_reg, load_resp_valid, load_resp_data,
        output query_reg_1, query_reg_2,
        input  alu_ready, load_issue_ready, stall_1, stall_2,
        input  write_enable, write_reg, write_data, loads_pending
    );

endinterface

// File: rtl/mips_cpu_tag_fifo.sv
// Circular FIFO of pending load destination tags, with per-entry match
// vectors so issue logic can see whether a queried register is still in flight.
module mips_cpu_tag_fifo
    import mips_cpu_pkg::*;
#(
    parameter int LOAD_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  reg_idx_t                    push_tag,
    input  logic                        pop,
    output reg_idx_t                    head_tag,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(LOAD_DEPTH):0] count,
    input  reg_idx_t                    query_1,
    input  reg_idx_t                    query_2,
    output logic [LOAD_DEPTH-1:0]       match_1,
    output logic [LOAD_DEPTH-1:0]       match_2
);

    localparam int PW = $clog2(LOAD_DEPTH);
    localparam int CW = PW + 1;

    reg_idx_t              tag_mem [LOAD_DEPTH];
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [CW-1:0]         count_q;
    logic [LOAD_DEPTH-1:0] entry_valid;
    logic [PW-1:0]         offset;

    assign head_tag = tag_mem[rd_ptr];
    assign full     = (count_q == CW'(LOAD_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < LOAD_DEPTH; i++) tag_mem[i] <= REG_ZERO;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= push_tag;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        entry_valid = '0;
        match_1     = '0;
        match_2     = '0;
        offset      = '0;
        for (int i = 0; i < LOAD_DEPTH; i++) begin
            offset         = PW'(i) - rd_ptr;
            entry_valid[i] = ({1'b0, offset} < count_q);
            match_1[i]     = entry_valid[i] && (tag_mem[i] == query_1);
            match_2[i]     = entry_valid[i] && (tag_mem[i] == query_2);
        end
    end

endmodule

// File: rtl/mips_cpu_writeback.sv
// Register-file write-port arbiter: load responses, then held ALU results, then fresh ALU results.
// Optional MIPS_WB_BYPASS_EN turns last-cycle write matches into forwarding hits instead of stalls.
module mips_cpu_writeback
    import mips_cpu_pkg::*;
#(
    parameter int LOAD_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    mips_cpu_writeback_if.master      bus
);

    localparam int CW = $clog2(LOAD_DEPTH) + 1;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    reg_idx_t              head_tag;
    logic [CW-1:0]         fifo_count;
    logic [LOAD_DEPTH-1:0] match_1;
    logic [LOAD_DEPTH-1:0] match_2;

    logic                  hold_valid;
    wb_req_t               hold_entry;
    logic                  alu_xfer;
    logic                  sel_valid;
    wb_req_t               sel;
    logic                  wr_en_q;
    wb_req_t               wr_q;

    logic                  hit_a1, hit_b1, hit_c1;
    logic                  hit_a2, hit_b2, hit_c2;

    assign alu_xfer  = bus.alu_valid && !hold_valid;
    assign fifo_pop  = bus.load_resp_valid && !fifo_empty;
    // A full FIFO still accepts an issue when a response frees the head slot in the same cycle.
    assign fifo_push = bus.load_issue && (!fifo_full || fifo_pop);

    assign bus.alu_ready        = !hold_valid;
    assign bus.load_issue_ready = !fifo_full;
    assign bus.loads_pending    = fifo_count;
    assign bus.write_enable     = wr_en_q;
    assign bus.write_reg        = wr_q.dest;
    assign bus.write_data       = wr_q.data;

    mips_cpu_tag_fifo #(.LOAD_DEPTH(LOAD_DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_tag (bus.load_issue_reg),
        .pop      (fifo_pop),
        .head_tag (head_tag),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count),
        .query_1  (bus.query_reg_1),
        .query_2  (bus.query_reg_2),
        .match_1  (match_1),
        .match_2  (match_2)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel       = '0;
        if (fifo_pop) begin
            sel_valid = 1'b1;
            sel       = '{dest: head_tag, data: bus.load_resp_data};
        end else if (hold_valid) begin
            sel_valid = 1'b1;
            sel       = hold_entry;
        end else if (alu_xfer) begin
            sel_valid = 1'b1;
            sel       = '{dest: bus.alu_reg, data: bus.alu_data};
        end
    end

    // An accepted ALU result only loses the port to a load response, so that is when it is parked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_valid <= 1'b0;
            hold_entry <= '0;
            wr_en_q    <= 1'b0;
            wr_q       <= '0;
        end else begin
            if (alu_xfer && fifo_pop) begin
                hold_valid <= 1'b1;
                hold_entry <= '{dest: bus.alu_reg, data: bus.alu_data};
            end else if (hold_valid && !fifo_pop) begin
                hold_valid <= 1'b0;
            end
            wr_en_q <= sel_valid && (sel.dest != REG_ZERO);
            if (sel_valid) wr_q <= sel;
        end
    end

    assign hit_a1 = |match_1;
    assign hit_b1 = hold_valid && (hold_entry.dest == bus.query_reg_1);
    assign hit_c1 = wr_en_q && (wr_q.dest == bus.query_reg_1);
    assign hit_a2 = |match_2;
    assign hit_b2 = hold_valid && (hold_entry.dest == bus.query_reg_2);
    assign hit_c2 = wr_en_q && (wr_q.dest == bus.query_reg_2);

`ifdef MIPS_WB_BYPASS_EN
    assign bus.stall_1       = (bus.query_reg_1 != REG_ZERO) && (hit_a1 || hit_b1);
    assign bus.stall_2       = (bus.query_reg_2 != REG_ZERO) && (hit_a2 || hit_b2);
    assign bus.bypass_hit_1  = (bus.query_reg_1 != REG_ZERO) && hit_c1;
    assign bus.bypass_hit_2  = (bus.query_reg_2 != REG_ZERO) && hit_c2;
    assign bus.bypass_data_1 = wr_q.data;
    assign bus.bypass_data_2 = wr_q.data;
`else
    assign bus.stall_1 = (bus.query_reg_1 != REG_ZERO) && (hit_a1 || hit_b1 || hit_c1);
    assign bus.stall_2 = (bus.query_reg_2 != REG_ZERO) && (hit_a2 || hit_b2 || hit_c2);
`endif

`ifndef SYNTHESIS
    logic waw_hit;

    always_comb begin
        waw_hit = 1'b0;
        for (int i = 0; i < LOAD_DEPTH; i++) begin
            if (u_fifo.entry_valid[i] && (u_fifo.tag_mem[i] == bus.alu_reg)) waw_hit = 1'b1;
        end
    end

    // A response with nothing outstanding is only legal alongside an issue into the empty FIFO.
    a_resp_without_load: assert property (@(posedge clk) disable iff (reset)
        (bus.load_resp_valid && !bus.load_issue) |-> !fifo_empty)
        else $error("load response with no outstanding load");

    a_alu_waw: assert property (@(posedge clk) disable iff (reset)
        (alu_xfer && (bus.alu_reg != REG_ZERO)) |-> !waw_hit)
        else $error("ALU write to a register with a pending load");
`endif

endmodule

// File: tb/tb_mips_cpu_writeback.sv
// Directed bench for mips_cpu_writeback: expected register-file writes go into a
// scoreboard queue that a negedge monitor drains; status outputs are checked inline.
module tb_mips_cpu_writeback;
    import mips_cpu_pkg::*;

    localparam int LOAD_DEPTH = 2;
`ifdef MIPS_WB_BYPASS_EN
    localparam bit BYPASS_ON = 1'b1;
`else
    localparam bit BYPASS_ON = 1'b0;
`endif

    logic    clk   = 1'b0;
    logic    reset = 1'b1;
    int      checks   = 0;
    int      failures = 0;
    wb_req_t exp_q[$];
    wb_req_t exp_head;

    mips_cpu_writeback_if #(.LOAD_DEPTH(LOAD_DEPTH)) bus ();

    mips_cpu_writeback #(.LOAD_DEPTH(LOAD_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic av, input reg_idx_t ar, input word_t ad,
                                 input logic li, input reg_idx_t lr,
                                 input logic rv, input word_t rd);
        bus.alu_valid       = av;
        bus.alu_reg         = ar;
        bus.alu_data        = ad;
        bus.load_issue      = li;
        bus.load_issue_reg  = lr;
        bus.load_resp_valid = rv;
        bus.load_resp_data  = rd;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0);
    endtask

    task automatic cycleEnd();
        @(posedge clk);
        #1;
    endtask

    task automatic expectWrite(input reg_idx_t dest, input word_t data);
        exp_q.push_back('{dest: dest, data: data});
    endtask

    // Every strobed write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && bus.write_enable) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_write: got reg %0d data 0x%0h, expected no write",
                         bus.write_reg, bus.write_data);
            end else begin
                exp_head = exp_q.pop_front();
                checkOutput("sb_write_reg", 32'(bus.write_reg), 32'(exp_head.dest));
                checkOutput("sb_write_data", bus.write_data, exp_head.data);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle();
        bus.query_reg_1 = 5'd5;
        bus.query_reg_2 = 5'd0;

        @(negedge clk);
        checkOutput("rst_write_enable", 32'(bus.write_enable), 32'd0);
        checkOutput("rst_write_reg", 32'(bus.write_reg), 32'd0);
        checkOutput("rst_write_data", bus.write_data, 32'd0);
        checkOutput("rst_loads_pending", 32'(bus.loads_pending), 32'd0);
        checkOutput("rst_alu_ready", 32'(bus.alu_ready), 32'd1);
        checkOutput("rst_issue_ready", 32'(bus.load_issue_ready), 32'd1);
        checkOutput("rst_stall_1", 32'(bus.stall_1), 32'd0);
        cycleEnd();
        reset = 1'b0;

        // ALU result straight to the port
        applyStimulus(1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 32'd0);
        expectWrite(5'd5, 32'h1234_5678);
        @(negedge clk);
        checkOutput("alu_ready_c0", 32'(bus.alu_ready), 32'd1);
        checkOutput("alu_stall_c0", 32'(bus.stall_1), 32'd0);
        cycleEnd();
        idle();
        @(negedge clk);
        checkOutput("alu_stall_c1", 32'(bus.stall_1), 32'(!BYPASS_ON));
`ifdef MIPS_WB_BYPASS_EN
        checkOutput("alu_bypass_hit_c1", 32'(bus.bypass_hit_1), 32'd1);
        checkOutput("alu_bypass_data_c1", bus.bypass_data_1, 32'h1234_5678);
`endif
        cycleEnd();
        @(negedge clk);
        checkOutput("alu_stall_c2", 32'(bus.stall_1), 32'd0);
        checkOutput("alu_we_c2", 32'(bus.write_enable), 32'd0);
        cycleEnd();

        // Pending load holds off its destination until written back
        bus.query_reg_1 = 5'd8;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("ld_issue_ready", 32'(bus.load_issue_ready), 32'd1);
        checkOutput("ld_stall_c0", 32'(bus.stall_1), 32'd0);
        cycleEnd();
        idle();
        @(negedge clk);
        checkOutput("ld_pending_c1", 32'(bus.loads_pending), 32'd1);
        checkOutput("ld_stall_c1", 32'(bus.stall_1), 32'd1);
        cycleEnd();
        @(negedge clk);
        checkOutput("ld_stall_c2", 32'(bus.stall_1), 32'd1);
        cycleEnd();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'hDEAD_BEEF);
        expectWrite(5'd8, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("ld_stall_resp", 32'(bus.stall_1), 32'd1);
        cycleEnd();
        idle();
        @(negedge clk);
        checkOutput("ld_pending_after", 32'(bus.loads_pending), 32'd0);
        checkOutput("ld_stall_wb", 32'(bus.stall_1), 32'(!BYPASS_ON));
        cycleEnd();
        @(negedge clk);
        checkOutput("ld_stall_clear", 32'(bus.stall_1), 32'd0);
        cycleEnd();

        // Load response and ALU result collide
        bus.query_reg_1 = 5'd0;
        bus.query_reg_2 = 5'd3;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 32'd0);
        cycleEnd();
        applyStimulus(1'b1, 5'd3, 32'h0000_000A, 1'b0, 5'd0, 1'b1, 32'h0000_000B);
        expectWrite(5'd9, 32'h0000_000B);
        expectWrite(5'd3, 32'h0000_000A);
        @(negedge clk);
        checkOutput("col_alu_ready_n", 32'(bus.alu_ready), 32'd1);
        cycleEnd();
        idle();
        @(negedge clk);
        checkOutput("col_alu_ready_n1", 32'(bus.alu_ready), 32'd0);
        checkOutput("col_write_reg_n1", 32'(bus.write_reg), 32'd9);
        checkOutput("col_stall_hold", 32'(bus.stall_2), 32'd1);
        cycleEnd();
        @(negedge clk);
        checkOutput("col_alu_ready_n2", 32'(bus.alu_ready), 32'd1);
        checkOutput("col_write_reg_n2", 32'(bus.write_reg), 32'd3);
        checkOutput("col_stall_n2", 32'(bus.stall_2), 32'(!BYPASS_ON));
        cycleEnd();

        // Fill the FIFO, then stream issue+response pairs through it so the pointers wrap
        bus.query_reg_2 = 5'd0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0, 32'd0);
        cycleEnd();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("full_ready_one", 32'(bus.load_issue_ready), 32'd1);
        cycleEnd();
        idle();
        @(negedge clk);
        checkOutput("full_ready", 32'(bus.load_issue_ready), 32'd0);
        checkOutput("full_pending", 32'(bus.loads_pending), 32'd2);
        cycleEnd();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'(12 + k), 1'b1, 32'h100 + 32'(k));
            expectWrite(5'(10 + k), 32'h100 + 32'(k));
            @(negedge clk);
            checkOutput("wrap_pending", 32'(bus.loads_pending), 32'd2);
            checkOutput("wrap_ready", 32'(bus.load_issue_ready), 32'd0);
            cycleEnd();
        end
        idle();
        @(negedge clk);
        checkOutput("wrap_pending_after", 32'(bus.loads_pending), 32'd2);
        cycleEnd();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h106);
        expectWrite(5'd16, 32'h106);
        cycleEnd();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h107);
        expectWrite(5'd17, 32'h107);
        cycleEnd();
        idle();
        @(negedge clk);
        checkOutput("drain_pending", 32'(bus.loads_pending), 32'd0);
        checkOutput("drain_ready", 32'(bus.load_issue_ready), 32'd1);
        cycleEnd();

        // $zero destinations never strobe the register file
        bus.query_reg_1 = 5'd0;
        applyStimulus(1'b1, 5'd0, 32'h0000_FFFF, 1'b0, 5'd0, 1'b0, 32'd0);
        @(negedge clk);
        checkOutput("zero_stall_c0", 32'(bus.stall_1), 32'd0);
        cycleEnd();
        idle();
        @(negedge clk);
        checkOutput("zero_we_alu", 32'(bus.write_enable), 32'd0);
        checkOutput("zero_stall_alu", 32'(bus.stall_1), 32'd0);
        cycleEnd();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 32'd0);
        cycleEnd();
        idle();
        @(negedge clk);
        checkOutput("zero_pending", 32'(bus.loads_pending), 32'd1);
        checkOutput("zero_stall_ld", 32'(bus.stall_1), 32'd0);
        cycleEnd();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h55);
        cycleEnd();
        idle();
        @(negedge clk);
        checkOutput("zero_pending_after", 32'(bus.loads_pending), 32'd0);
        checkOutput("zero_we_ld", 32'(bus.write_enable), 32'd0);
        cycleEnd();

        // Reset with two loads in flight and the hold register occupied
        bus.query_reg_1 = 5'd21;
        bus.query_reg_2 = 5'd23;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 1'b0, 32'd0);
        cycleEnd();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd21, 1'b0, 32'd0);
        cycleEnd();
        applyStimulus(1'b1, 5'd23, 32'h77, 1'b1, 5'd22, 1'b1, 32'h1111);
        expectWrite(5'd20, 32'h1111);
        @(negedge clk);
        checkOutput("rm_alu_ready_pre", 32'(bus.alu_ready), 32'd1);
        cycleEnd();
        idle();
        @(negedge clk);
        checkOutput("rm_alu_ready_hold", 32'(bus.alu_ready), 32'd0);
        checkOutput("rm_pending", 32'(bus.loads_pending), 32'd2);
        checkOutput("rm_stall_fifo", 32'(bus.stall_1), 32'd1);
        checkOutput("rm_stall_hold", 32'(bus.stall_2), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("rm_write_enable", 32'(bus.write_enable), 32'd0);
        checkOutput("rm_write_reg", 32'(bus.write_reg), 32'd0);
        checkOutput("rm_write_data", bus.write_data, 32'd0);
        checkOutput("rm_loads_pending", 32'(bus.loads_pending), 32'd0);
        checkOutput("rm_alu_ready", 32'(bus.alu_ready), 32'd1);
        checkOutput("rm_issue_ready", 32'(bus.load_issue_ready), 32'd1);
        checkOutput("rm_stall_1", 32'(bus.stall_1), 32'd0);
        checkOutput("rm_stall_2", 32'(bus.stall_2), 32'd0);
        cycleEnd();
        reset = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd24, 1'b1, 32'h2222);
        cycleEnd();
        idle();
        @(negedge clk);
        checkOutput("rm_resp_ignored", 32'(bus.write_enable), 32'd0);
        checkOutput("rm_pending_after", 32'(bus.loads_pending), 32'd1);
        cycleEnd();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h99);
        expectWrite(5'd24, 32'h99);
        cycleEnd();
        idle();
        cycleEnd();
        cycleEnd();

        checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_cpu_writeback.md
Name: mips_cpu_writeback

Overview:
- Register-file write-side initiator for the MIPS datapath.
- Accepts ALU results and variable-latency load responses, arbitrates them onto the register file's single write port, and tracks pending load destinations.
- Gives issue logic per-operand stall indications so reads never observe stale data.
- Sits between the execute/memory stages and the register file's write_enable/write_reg/write_data inputs.

Parameters:
- LOAD_DEPTH, 2, maximum outstanding loads (depth of the destination-tag FIFO, power of two, at least 2).

Ports:
- clk  input  1  system clock; all state on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU result presented.
- alu_ready  output  1  ALU result accepted this cycle; equals !hold_valid.
- alu_reg  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- load_issue  input  1  load issued; reserves its destination.
- load_issue_ready  output  1  tag FIFO not full.
- load_issue_reg  input  5  load destination register.
- load_resp_valid  input  1  load data returned; in order, one per cycle.
- load_resp_data  input  32  load data.
- query_reg_1  input  5  operand 1 under test.
- query_reg_2  input  5  operand 2 under test.
- stall_1  output  1  operand 1 not yet readable.
- stall_2  output  1  operand 2 not yet readable.
- write_enable  output  1  register file write strobe.
- write_reg  output  5  register file write index.
- write_data  output  32  register file write data.
- loads_pending  output  $clog2(LOAD_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, active-high): write_enable=0, write_reg=0, write_data=0, FIFO empty, hold empty, loads_pending=0, alu_ready=1, load_issue_ready=1, stall_1/2=0.
- Effect of a mid-operation reset: all in-flight loads and held results are discarded.
- Handshakes:
  - ALU transfer occurs on alu_valid && alu_ready.
  - Issue transfer occurs on load_issue && load_issue_ready.
- Hold register: one entry for ALU results.
- Write-port selection per cycle, in priority order:
  - (1) load_resp_valid with a non-empty FIFO: pop the head tag and write load_resp_data to it.
  - (2) otherwise, if hold_valid: drain the hold entry.
  - (3) otherwise, a transferring ALU result goes straight to the write port.
- An ALU transfer not granted the port loads the hold register.
- Latency: the selected write appears registered on write_enable/write_reg/write_data in the cycle after selection, for exactly one cycle. The register file commits at the end of that cycle.
- $zero handling:
  - Any selected write with destination 0 produces write_enable=0, but still consumes its FIFO slot or hold entry.
  - A load to $0 still occupies a FIFO slot.
- Tag FIFO:
  - Circular; read and write pointers wrap modulo LOAD_DEPTH.
  - Simultaneous issue and response while full is legal: pop and push together, occupancy unchanged.
  - load_issue_ready = !full, independent of load_resp_valid.
  - Simultaneous issue and response while empty: no pop, the push succeeds, and the response is ignored.
- stall_n asserts combinationally when query_reg_n != 0 and any of the following holds:
  - (a) it matches any valid FIFO entry;
  - (b) it matches the hold entry;
  - (c) it matches write_reg while write_enable=1.
- Protocol violations: flagged by simulation-only assertions; RTL behaviour in these cases is "ignore response" or "write in port order".
  - load_resp_valid with an empty FIFO.
  - ALU write to a register currently pending in the FIFO (WAW).
- Arithmetic: pointers are $clog2(LOAD_DEPTH) bits; occupancy is one bit wider.

Optional Feature:
- Macro: MIPS_WB_BYPASS_EN.
- Defined:
  - Adds outputs bypass_hit_1, bypass_hit_2 (1 bit each) and bypass_data_1, bypass_data_2 (32 bits each).
  - A stall case (c) match raises bypass_hit_n with bypass_data_n = write_data, and drops stall_n for that case.
  - Cases (a) and (b) still stall.
- Undefined: those ports are absent; case (c) stalls.

Decomposition:
- Shared package mips_cpu_pkg holds:
  - typedef reg_idx_t (5 bits);
  - typedef word_t (32 bits);
  - constant REG_ZERO = 5'd0.
- One sub-module, mips_cpu_tag_fifo:
  - parameterised by LOAD_DEPTH;
  - push/pop ports, head tag output, full/empty flags, count;
  - a per-entry match vector against two query indices.

Test Plan:
- ALU only: alu_valid, reg 5, data 0x1234_5678 in cycle 0 → cycle 1 has write_enable=1, write_reg=5, write_data=0x12345678; stall_1 with query 5 high in cycle 1 only.
- Load pending: issue load to reg 8, query_reg_1=8 → stall_1=1 until the response with 0xDEADBEEF arrives; write appears the next cycle, and stall clears the cycle after.
- Collision: ALU reg 3 = 0xA and load response to reg 9 = 0xB in the same cycle → reg 9 written at N+1, reg 3 at N+2; alu_ready=0 during N+1.
- FIFO full and wrap: with LOAD_DEPTH=2, issue 2 loads → load_issue_ready=0; simultaneous response and issue keeps occupancy 2; 6 round-trips return data in order.
- $zero: ALU write to reg 0 and load to reg 0 → write_enable never asserts; loads_pending returns to 0; stall never asserts for query 0.
- Reset mid-operation: 2 loads pending and hold full, assert reset → all outputs reach reset values immediately, and a later response is ignored.
